alu_core: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_if.sv | 22 ++
 rtl/alu_comb.sv | 41 ++++
 rtl/alu_core.sv | 43 ++++
 tb/tb_alu_core.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// +-----------------------------------------------------------------------+
// | alu_pkg : shared widths and R-type function codes for the ALU         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int NB_DATA = 6;
  localparam int NB_OP   = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_if.sv
// +-----------------------------------------------------------------------+
// | alu_if : operand/function-code bus and registered result of the ALU   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface alu_if #(
  parameter int NB_DATA = alu_pkg::NB_DATA,
  parameter int NB_OP   = alu_pkg::NB_OP
);

  logic [NB_DATA-1:0] i_A;
  logic [NB_DATA-1:0] i_B;
  logic [NB_OP-1:0]   i_OP;
  logic [NB_DATA-1:0] o_res;

  modport master (output i_A, output i_B, output i_OP, input  o_res);
  modport slave  (input  i_A, input  i_B, input  i_OP, output o_res);

endinterface : alu_if

`default_nettype wire

// File: rtl/alu_comb.sv
// +-----------------------------------------------------------------------+
// | alu_comb : combinational function-code decoder and ALU datapath       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_comb #(
  parameter int NB_DATA = alu_pkg::NB_DATA,
  parameter int NB_OP   = alu_pkg::NB_OP
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] res_o
);

  import alu_pkg::*;

  localparam logic [NB_DATA-1:0] SH_LIMIT = NB_DATA'(NB_DATA);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD: res_o = a_i + b_i;
      OP_SUB: res_o = a_i - b_i;
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_NOR: res_o = ~(a_i | b_i);
      // Oversized shift amounts saturate explicitly rather than relying on
      // shifter behaviour for counts beyond the operand width.
      OP_SRL: res_o = (b_i >= SH_LIMIT) ? '0 : (a_i >> b_i);
      OP_SRA: res_o = (b_i >= SH_LIMIT) ? {NB_DATA{a_i[NB_DATA-1]}}
                                        : NB_DATA'($signed(a_i) >>> b_i);
      default: res_o = '0;
    endcase
  end

endmodule : alu_comb

`default_nettype wire

// File: rtl/alu_core.sv
// +-----------------------------------------------------------------------+
// | alu_core : R-type ALU with a synchronously reset registered result    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_core #(
  parameter int NB_DATA = alu_pkg::NB_DATA,
  parameter int NB_OP   = alu_pkg::NB_OP
) (
  input  logic  clock,
  input  logic  reset,
  alu_if.slave  bus
);

  import alu_pkg::*;

  logic [NB_DATA-1:0] res_d;
  logic [NB_DATA-1:0] res_q;

  alu_comb #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu_comb (
    .a_i   (bus.i_A),
    .b_i   (bus.i_B),
    .op_i  (bus.i_OP),
    .res_o (res_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.o_res = res_q;

endmodule : alu_core

`default_nettype wire

// File: tb/tb_alu_core.sv
// +-----------------------------------------------------------------------+
// | tb_alu_core : scoreboard bench for the registered R-type ALU          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_alu_core;

  import alu_pkg::*;

  localparam int W = NB_DATA;

  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [NB_OP-1:0] op;
    logic [W-1:0]     exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [W-1:0] sb[$];

  always #5 clock = ~clock;

  alu_if #(.NB_DATA(W), .NB_OP(NB_OP)) bus ();

  alu_core #(.NB_DATA(W), .NB_OP(NB_OP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Independent reference built on plain integers.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [NB_OP-1:0] op);
    int ia, ib, mask, r;
    ia = int'(a); ib = int'(b); mask = (1 << W) - 1; r = 0;
    case (op)
      OP_ADD: r = (ia + ib) & mask;
      OP_SUB: r = (ia - ib + (1 << W)) & mask;
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_XOR: r = ia ^ ib;
      OP_NOR: r = ~(ia | ib) & mask;
      OP_SRL: r = (ib >= W) ? 0 : (ia / (1 << ib));
      OP_SRA: begin
        if (ib >= W) r = a[W-1] ? mask : 0;
        else begin
          r = ia / (1 << ib);
          if (a[W-1]) r = r | (mask & ~((1 << (W - ib)) - 1));
        end
      end
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [NB_OP-1:0] op, input logic rst, input logic [W-1:0] exp);
    bus.i_A  = a;
    bus.i_B  = b;
    bus.i_OP = op;
    reset    = rst;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(6'd5, 6'd3, OP_ADD, (i < 2), (i < 2) ? 6'd0 : 6'd8);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.o_res !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: o_res=%0d expected %0d", i, bus.o_res, e);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[4] = '{'{6'd2,  6'd3, OP_ADD, 6'd5},
                   '{6'd6,  6'd5, OP_SUB, 6'd1},
                   '{6'd63, 6'd1, OP_ADD, 6'd0},
                   '{6'd0,  6'd1, OP_SUB, 6'd63}};
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b0, v[i].exp);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.o_res !== e) begin
        n_bad++;
        $display("FAIL arith[%0d]: o_res=%0d expected %0d", i, bus.o_res, e);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[4] = '{'{6'd7, 6'd7,  OP_AND, 6'd7},
                   '{6'd5, 6'd2,  OP_OR,  6'd7},
                   '{6'd8, 6'd2,  OP_XOR, 6'd10},
                   '{6'd8, 6'd12, OP_NOR, 6'd51}};
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b0, v[i].exp);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.o_res !== e) begin
        n_bad++;
        $display("FAIL logic[%0d]: o_res=%0d expected %0d", i, bus.o_res, e);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[9] = '{'{6'd15, 6'd1,  OP_SRL, 6'd7},
                   '{6'd15, 6'd1,  OP_SRA, 6'd7},
                   '{6'd32, 6'd1,  OP_SRL, 6'd16},
                   '{6'd32, 6'd1,  OP_SRA, 6'd48},
                   '{6'd32, 6'd6,  OP_SRL, 6'd0},
                   '{6'd32, 6'd7,  OP_SRA, 6'd63},
                   '{6'd15, 6'd0,  OP_SRA, 6'd15},
                   '{6'd45, 6'd0,  OP_SRL, 6'd45},
                   '{6'd21, 6'd63, OP_SRA, 6'd0}};
    logic [W-1:0] e;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b0, v[i].exp);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.o_res !== e) begin
        n_bad++;
        $display("FAIL shift[%0d]: o_res=%0d expected %0d", i, bus.o_res, e);
      end
    end
  endtask

  task automatic test_illegal_and_reset_priority();
    logic [W-1:0] e;
    drive(6'd9, 6'd4, 6'b111111, 1'b0, 6'd0);
    @(posedge clock); #1;
    e = sb.pop_front();
    n_vec++;
    if (bus.o_res !== e) begin
      n_bad++;
      $display("FAIL illegal_op: o_res=%0d expected %0d", bus.o_res, e);
    end
    drive(6'd1, 6'd1, OP_ADD, 1'b1, 6'd0);
    @(posedge clock); #1;
    e = sb.pop_front();
    n_vec++;
    if (bus.o_res !== e) begin
      n_bad++;
      $display("FAIL reset_priority: o_res=%0d expected %0d", bus.o_res, e);
    end
    drive(6'd1, 6'd1, OP_ADD, 1'b0, 6'd2);
    @(posedge clock); #1;
    e = sb.pop_front();
    n_vec++;
    if (bus.o_res !== e) begin
      n_bad++;
      $display("FAIL reset_release: o_res=%0d expected %0d", bus.o_res, e);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    drive(6'd20, 6'd9, OP_ADD, 1'b0, 6'd29);
    @(posedge clock); #1;
    e = sb.pop_front();
    bus.i_A  = 6'd3;
    bus.i_B  = 6'd3;
    bus.i_OP = OP_XOR;
    #3;
    n_vec++;
    if (bus.o_res !== e) begin
      n_bad++;
      $display("FAIL hold_mid_cycle: o_res=%0d expected %0d", bus.o_res, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [NB_OP-1:0] ops[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                                 OP_XOR, OP_NOR, OP_SRL, OP_SRA};
    logic [W-1:0] a, b, e;
    for (int i = 0; i < 32; i++) begin
      a = W'($urandom);
      b = (ops[i % 8] == OP_SRL || ops[i % 8] == OP_SRA) ? W'($urandom_range(0, 9))
                                                         : W'($urandom);
      drive(a, b, ops[i % 8], 1'b0, model(a, b, ops[i % 8]));
      @(posedge clock); #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.o_res !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: op=%b a=%0d b=%0d o_res=%0d expected %0d",
                 i, ops[i % 8], a, b, bus.o_res, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    bus.i_A  = '0;
    bus.i_B  = '0;
    bus.i_OP = '0;
    @(negedge clock);
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_illegal_and_reset_priority();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_alu_core

`default_nettype wire
